// File: rtl/escalonador_pkg.sv
// Shared types for the quantum preemption scheduler: FSM states, trap causes, OS PID.
package escalonador_pkg;

  localparam int unsigned PID_W_DEF    = 4;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned QUANTUM_DEF  = 64;
  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned CAUSA_W      = 2;
  localparam int unsigned CAUSA_WORD_W = 32;
  localparam int unsigned PID_OS       = 0;

  typedef enum logic [1:0] {
    SO     = 2'd0,
    USER   = 2'd1,
    TRAP   = 2'd2,
    HALTED = 2'd3
  } estado_t;

  typedef enum logic [CAUSA_W-1:0] {
    CAUSA_NENHUMA = 2'd0,
    CAUSA_QUANTUM = 2'd1,
    CAUSA_WAIT    = 2'd2
  } causa_t;

  // Zero-extended cause word as written to the register file by PREEMP_TO_REG.
  function automatic logic [CAUSA_WORD_W-1:0] palavra_causa(input causa_t c);
    return {(CAUSA_WORD_W - CAUSA_W)'(0), c};
  endfunction

endpackage

// File: rtl/escalonador_preempcao_if.sv
// Control-unit <-> scheduler signal bundle; master is the core, slave is the scheduler.
interface escalonador_preempcao_if
  import escalonador_pkg::*;
#(
  parameter int unsigned PID_W = PID_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PC_W  = PC_W_DEF
);

  logic                    Set_ctx;
  logic                    Set_pid_0;
  logic                    Check_preemp;
  logic                    WAIT;
  logic                    HALT;
  logic [PID_W-1:0]        pid_in;
  logic [PC_W-1:0]         pc_in;
  logic                    quantum_wr;
  logic [CNT_W-1:0]        quantum_data;

  logic [PID_W-1:0]        pid_atual;
  logic                    trap_req;
  logic [PC_W-1:0]         pc_salvo;
  logic [CAUSA_WORD_W-1:0] causa_preemp;
  logic [CNT_W-1:0]        contador;
  logic                    halted;

  modport master (
    output Set_ctx, Set_pid_0, Check_preemp, WAIT, HALT,
    output pid_in, pc_in, quantum_wr, quantum_data,
    input  pid_atual, trap_req, pc_salvo, causa_preemp, contador, halted
  );

  modport slave (
    input  Set_ctx, Set_pid_0, Check_preemp, WAIT, HALT,
    input  pid_in, pc_in, quantum_wr, quantum_data,
    output pid_atual, trap_req, pc_salvo, causa_preemp, contador, halted
  );

endinterface

// File: rtl/escalonador_preempcao_contador_quantum.sv
// Quantum down-counter: clear beats load beats decrement; saturates at zero.
module contador_quantum #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic             clear,
  input  logic [CNT_W-1:0] valor,
  output logic [CNT_W-1:0] contador,
  output logic             ultimo_c
);

  always_ff @(posedge clock) begin
    if (reset) begin
      contador <= '0;
    end else if (clear) begin
      contador <= '0;
    end else if (load) begin
      contador <= valor;
    end else if (dec && (contador != '0)) begin
      contador <= contador - CNT_W'(1);
    end
  end

  // Last cycle of the quantum: expiry is decided on this value.
  assign ultimo_c = (contador == CNT_W'(1));

endmodule

// File: rtl/escalonador_preempcao.sv
// Quantum-based preemption scheduler: tracks running PID, raises a 1-cycle trap to the OS.
module escalonador_preempcao
  import escalonador_pkg::*;
#(
  parameter int unsigned PID_W   = PID_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned QUANTUM = QUANTUM_DEF,
  parameter int unsigned PC_W    = PC_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  escalonador_preempcao_if.slave  bus
);

  estado_t          estado;
  causa_t           causa_reg;
  logic [PID_W-1:0] pid_reg;
  logic [CNT_W-1:0] quantum_reg;
  logic [PC_W-1:0]  pc_salvo_reg;
  logic             trap_reg;
  logic             halted_reg;

  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic             cnt_clear_c;
  logic             ultimo_c;
  logic             ctx_valido_c;
  logic [CNT_W-1:0] contador_val;

  assign ctx_valido_c = bus.Set_ctx && (bus.pid_in != PID_W'(PID_OS));

  // Counter control mirrors the FSM transitions; HALT freezes the count.
  always_comb begin
    cnt_load_c  = 1'b0;
    cnt_dec_c   = 1'b0;
    cnt_clear_c = 1'b0;
    if (!bus.HALT) begin
      unique case (estado)
        SO:      cnt_load_c  = ctx_valido_c;
        USER: begin
          cnt_clear_c = bus.Set_pid_0;
          cnt_dec_c   = !bus.Set_pid_0;
        end
        TRAP:    cnt_clear_c = 1'b1;
        default: ;
      endcase
    end
  end

  contador_quantum #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load_c),
    .dec      (cnt_dec_c),
    .clear    (cnt_clear_c),
    .valor    (quantum_reg),
    .contador (contador_val),
    .ultimo_c (ultimo_c)
  );

  // Scheduler FSM; trap_reg is set together with the move into TRAP so it tracks that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= SO;
      pid_reg      <= '0;
      quantum_reg  <= CNT_W'(QUANTUM);
      pc_salvo_reg <= '0;
      causa_reg    <= CAUSA_NENHUMA;
      trap_reg     <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      trap_reg <= 1'b0;
      if (bus.HALT) begin
        estado     <= HALTED;
        halted_reg <= 1'b1;
      end else begin
        unique case (estado)
          SO: begin
            if (bus.quantum_wr) begin
              quantum_reg <= (bus.quantum_data == '0) ? CNT_W'(1) : bus.quantum_data;
            end
            if (bus.Check_preemp) begin
              causa_reg <= CAUSA_NENHUMA;
            end
            if (ctx_valido_c) begin
              pid_reg <= bus.pid_in;
              estado  <= USER;
            end
          end
          USER: begin
            if (bus.Set_pid_0) begin
              pid_reg   <= PID_W'(PID_OS);
              causa_reg <= CAUSA_NENHUMA;
              estado    <= SO;
            end else if (bus.WAIT) begin
              causa_reg <= CAUSA_WAIT;
              estado    <= TRAP;
              trap_reg  <= 1'b1;
            end else if (ultimo_c) begin
              causa_reg <= CAUSA_QUANTUM;
              estado    <= TRAP;
              trap_reg  <= 1'b1;
            end
          end
          TRAP: begin
            pc_salvo_reg <= bus.pc_in;
            pid_reg      <= PID_W'(PID_OS);
            estado       <= SO;
          end
          HALTED: ;
          default: estado <= SO;
        endcase
      end
    end
  end

  assign bus.pid_atual    = pid_reg;
  assign bus.trap_req     = trap_reg;
  assign bus.pc_salvo     = pc_salvo_reg;
  assign bus.causa_preemp = palavra_causa(causa_reg);
  assign bus.contador     = contador_val;
  assign bus.halted       = halted_reg;

endmodule

// File: tb/tb_escalonador_preempcao.sv
// Scenario bench for escalonador_preempcao with a queue of expected trap captures.
module tb_escalonador_preempcao;
  import escalonador_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  escalonador_preempcao_if bus ();

  escalonador_preempcao dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] causa;
  } exp_trap_t;

  exp_trap_t fila[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.Set_ctx      = 1'b0;
    bus.Set_pid_0    = 1'b0;
    bus.Check_preemp = 1'b0;
    bus.WAIT         = 1'b0;
    bus.HALT         = 1'b0;
    bus.pid_in       = '0;
    bus.pc_in        = '0;
    bus.quantum_wr   = 1'b0;
    bus.quantum_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_quantum(input logic [15:0] q);
    bus.quantum_wr   = 1'b1;
    bus.quantum_data = q;
    tick();
    bus.quantum_wr   = 1'b0;
  endtask

  task automatic start_ctx(input logic [3:0] pid);
    bus.Set_ctx = 1'b1;
    bus.pid_in  = pid;
    tick();
    bus.Set_ctx = 1'b0;
  endtask

  task automatic test_reset();
    exp_trap_t e;
    do_reset();
    total++; if (bus.pid_atual !== 4'd0) begin bad++; $display("FAIL reset_pid got=%0d exp=0", bus.pid_atual); end
    total++; if (bus.contador !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.contador); end
    total++; if ({bus.trap_req, bus.halted} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bus.trap_req, bus.halted}); end
    total++; if (bus.pc_salvo !== 32'd0 || bus.causa_preemp !== 32'd0) begin bad++; $display("FAIL reset_pc_causa got=%h/%h exp=0/0", bus.pc_salvo, bus.causa_preemp); end
    e = '{pc: 32'h0, causa: 32'h0};
    e.pc = 32'h0;
  endtask

  task automatic test_quantum_expiry();
    exp_trap_t e;
    set_quantum(16'd5);
    start_ctx(4'd3);
    total++; if (bus.pid_atual !== 4'd3) begin bad++; $display("FAIL exp_pid got=%0d exp=3", bus.pid_atual); end
    total++; if (bus.contador !== 16'd5) begin bad++; $display("FAIL exp_load got=%0d exp=5", bus.contador); end
    for (int k = 4; k >= 1; k--) begin
      tick();
      total++;
      if (bus.contador !== 16'(k) || bus.trap_req !== 1'b0) begin
        bad++; $display("FAIL exp_count got=%0d/%b exp=%0d/0", bus.contador, bus.trap_req, k);
      end
    end
    tick();
    total++; if (bus.trap_req !== 1'b1) begin bad++; $display("FAIL exp_trap_latency got=%b exp=1", bus.trap_req); end
    total++; if (bus.causa_preemp !== 32'd1) begin bad++; $display("FAIL exp_causa got=%0d exp=1", bus.causa_preemp); end
    bus.pc_in = 32'h0000_0100;
    fila.push_back('{pc: 32'h0000_0100, causa: 32'd1});
    tick();
    bus.pc_in = '0;
    if (fila.size() == 0) begin total++; bad++; $display("FAIL exp_queue got=empty exp=entry"); end
    else begin
      e = fila.pop_front();
      total++; if (bus.pc_salvo !== e.pc) begin bad++; $display("FAIL exp_pc_salvo got=%h exp=%h", bus.pc_salvo, e.pc); end
      total++; if (bus.causa_preemp !== e.causa) begin bad++; $display("FAIL exp_causa_after got=%0d exp=%0d", bus.causa_preemp, e.causa); end
    end
    total++; if ({bus.trap_req, bus.pid_atual, bus.contador} !== {1'b0, 4'd0, 16'd0}) begin
      bad++; $display("FAIL exp_return got=%b/%0d/%0d exp=0/0/0", bus.trap_req, bus.pid_atual, bus.contador);
    end
  endtask

  task automatic test_voluntary_return();
    set_quantum(16'd3);
    start_ctx(4'd7);
    tick();
    tick();
    total++; if (bus.contador !== 16'd1) begin bad++; $display("FAIL vol_cnt got=%0d exp=1", bus.contador); end
    bus.Set_pid_0 = 1'b1;
    bus.WAIT      = 1'b1;
    tick();
    idle();
    total++; if (bus.trap_req !== 1'b0) begin bad++; $display("FAIL vol_notrap got=%b exp=0", bus.trap_req); end
    total++; if (bus.pid_atual !== 4'd0 || bus.causa_preemp !== 32'd0) begin
      bad++; $display("FAIL vol_state got=%0d/%0d exp=0/0", bus.pid_atual, bus.causa_preemp);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.trap_req !== 1'b0 || bus.contador !== 16'd0) begin
        bad++; $display("FAIL vol_idle got=%b/%0d exp=0/0", bus.trap_req, bus.contador);
      end
    end
  endtask

  task automatic test_wait_and_read_clear();
    exp_trap_t e;
    set_quantum(16'd10);
    start_ctx(4'd5);
    for (int k = 0; k < 6; k++) tick();
    total++; if (bus.contador !== 16'd4) begin bad++; $display("FAIL wait_cnt got=%0d exp=4", bus.contador); end
    bus.WAIT = 1'b1;
    tick();
    bus.WAIT = 1'b0;
    total++; if (bus.trap_req !== 1'b1 || bus.causa_preemp !== 32'd2) begin
      bad++; $display("FAIL wait_trap got=%b/%0d exp=1/2", bus.trap_req, bus.causa_preemp);
    end
    bus.pc_in = 32'h0000_0240;
    fila.push_back('{pc: 32'h0000_0240, causa: 32'd2});
    tick();
    bus.pc_in = '0;
    if (fila.size() == 0) begin total++; bad++; $display("FAIL wait_queue got=empty exp=entry"); end
    else begin
      e = fila.pop_front();
      total++; if (bus.pc_salvo !== e.pc) begin bad++; $display("FAIL wait_pc_salvo got=%h exp=%h", bus.pc_salvo, e.pc); end
      bus.Check_preemp = 1'b1;
      #1;
      total++; if (bus.causa_preemp !== e.causa) begin bad++; $display("FAIL wait_read got=%0d exp=%0d", bus.causa_preemp, e.causa); end
    end
    tick();
    bus.Check_preemp = 1'b0;
    total++; if (bus.causa_preemp !== 32'd0) begin bad++; $display("FAIL wait_clear got=%0d exp=0", bus.causa_preemp); end
  endtask

  task automatic test_quantum_clamp();
    exp_trap_t e;
    set_quantum(16'd0);
    start_ctx(4'd2);
    total++; if (bus.contador !== 16'd1 || bus.pid_atual !== 4'd2) begin
      bad++; $display("FAIL clamp_load got=%0d/%0d exp=1/2", bus.contador, bus.pid_atual);
    end
    bus.quantum_wr   = 1'b1;
    bus.quantum_data = 16'd9;
    tick();
    bus.quantum_wr   = 1'b0;
    total++; if (bus.trap_req !== 1'b1 || bus.causa_preemp !== 32'd1) begin
      bad++; $display("FAIL clamp_trap got=%b/%0d exp=1/1", bus.trap_req, bus.causa_preemp);
    end
    bus.pc_in = 32'h0000_0300;
    fila.push_back('{pc: 32'h0000_0300, causa: 32'd1});
    tick();
    bus.pc_in = '0;
    if (fila.size() == 0) begin total++; bad++; $display("FAIL clamp_queue got=empty exp=entry"); end
    else begin
      e = fila.pop_front();
      total++; if (bus.pc_salvo !== e.pc) begin bad++; $display("FAIL clamp_pc_salvo got=%h exp=%h", bus.pc_salvo, e.pc); end
    end
    start_ctx(4'd2);
    total++; if (bus.contador !== 16'd1) begin bad++; $display("FAIL clamp_wr_user got=%0d exp=1", bus.contador); end
    tick();
    tick();
  endtask

  task automatic test_halt();
    set_quantum(16'd10);
    start_ctx(4'd4);
    for (int k = 0; k < 3; k++) tick();
    total++; if (bus.contador !== 16'd7) begin bad++; $display("FAIL halt_pre got=%0d exp=7", bus.contador); end
    bus.HALT = 1'b1;
    tick();
    bus.HALT = 1'b0;
    total++; if ({bus.halted, bus.trap_req} !== 2'b10 || bus.contador !== 16'd7) begin
      bad++; $display("FAIL halt_enter got=%b/%0d exp=10/7", {bus.halted, bus.trap_req}, bus.contador);
    end
    bus.Set_ctx = 1'b1;
    bus.pid_in  = 4'd6;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({bus.halted, bus.trap_req} !== 2'b10 || bus.contador !== 16'd7 || bus.pid_atual !== 4'd4) begin
        bad++; $display("FAIL halt_hold got=%b/%0d/%0d exp=10/7/4", {bus.halted, bus.trap_req}, bus.contador, bus.pid_atual);
      end
    end
    do_reset();
    total++; if ({bus.halted, bus.trap_req, bus.pid_atual, bus.contador} !== {2'b00, 4'd0, 16'd0}) begin
      bad++; $display("FAIL halt_reset got=%b/%0d/%0d exp=00/0/0", {bus.halted, bus.trap_req}, bus.pid_atual, bus.contador);
    end
    total++; if (bus.pc_salvo !== 32'd0 || bus.causa_preemp !== 32'd0) begin
      bad++; $display("FAIL halt_reset_regs got=%h/%0d exp=0/0", bus.pc_salvo, bus.causa_preemp);
    end
  endtask

  task automatic test_reset_in_trap();
    bit vista;
    set_quantum(16'd1);
    start_ctx(4'd9);
    vista = 1'b0;
    for (int k = 0; k < 4 && !vista; k++) begin
      tick();
      vista = bus.trap_req;
    end
    total++; if (vista !== 1'b1) begin bad++; $display("FAIL rst_trap_seen got=%b exp=1", vista); end
    bus.pc_in = 32'h000D_EAD0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    total++; if ({bus.trap_req, bus.pid_atual, bus.contador} !== {1'b0, 4'd0, 16'd0}) begin
      bad++; $display("FAIL rst_trap_state got=%b/%0d/%0d exp=0/0/0", bus.trap_req, bus.pid_atual, bus.contador);
    end
    total++; if (bus.pc_salvo !== 32'd0) begin bad++; $display("FAIL rst_trap_pc got=%h exp=0", bus.pc_salvo); end
    tick();
    total++; if (bus.trap_req !== 1'b0) begin bad++; $display("FAIL rst_trap_nopulse got=%b exp=0", bus.trap_req); end
    start_ctx(4'd1);
    total++; if (bus.contador !== 16'd64 || bus.pid_atual !== 4'd1) begin
      bad++; $display("FAIL rst_quantum_reload got=%0d/%0d exp=64/1", bus.contador, bus.pid_atual);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_quantum_expiry();
    test_voluntary_return();
    test_wait_and_read_clear();
    test_quantum_clamp();
    test_halt();
    test_reset_in_trap();
    if (fila.size() != 0) begin
      total++; bad++; $display("FAIL queue_leftover got=%0d exp=0", fila.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
